instr_fetch_queue: RTL and testbench

//  Instruction-fetch front end that feeds the main control decoder.

---
 rtl/instr_fetch_queue.sv | 163 ++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : Instruction-fetch front end. Issues in-order word fetches to
//               instruction memory under a credit limit, tags each request
//               with its PC, buffers returned words in a DEPTH-entry FIFO and
//               presents the oldest word (with PC and opcode) on a
//               valid/ready interface. A redirect flushes the FIFO, restarts
//               fetch at the new PC and drops responses still in flight.
// Ports       : clk, reset (async, active-high)
//               imem_req_valid/addr/ready  - fetch request channel
//               imem_rsp_valid/data        - in-order response channel
//               redirect_valid/pc          - fetch restart
//               inst_valid/inst/inst_pc/opcode, inst_ready - decoder side
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode,
    input  logic            inst_ready
);

    localparam int              c_AW    = $clog2(DEPTH);
    localparam int              c_CW    = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
    localparam logic [XLEN-1:0] c_NOP   = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [XLEN-1:0]   r_fetch_pc;
    logic [c_CW-1:0]   r_inflight;
    logic [c_CW-1:0]   r_drop_cnt;
    logic [c_CW-1:0]   r_count;
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW-1:0]   r_tag_wr;
    logic [c_AW-1:0]   r_tag_rd;
    logic [XLEN-1:0]   r_data [DEPTH];
    logic [XLEN-1:0]   r_pc   [DEPTH];
    logic [XLEN-1:0]   r_tag  [DEPTH];

    logic              w_req_valid;
    logic              w_accept;
    logic              w_rsp;
    logic              w_push;
    logic              w_pop;
    logic [c_CW-1:0]   w_inflight_next;
    logic [c_CW-1:0]   w_drop_next;
    logic [XLEN-1:0]   w_redirect_pc;

    // Buffered plus outstanding words never exceed DEPTH, so every response
    // that is kept always finds a free FIFO slot.
    assign w_req_valid     = (r_state != ST_IDLE) && ((r_inflight + r_count) < c_DEPTH);
    assign w_accept        = w_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp           = imem_rsp_valid && (r_inflight != '0);
    assign w_push          = w_rsp && (r_drop_cnt == '0) && !redirect_valid;
    assign w_pop           = inst_valid && inst_ready;
    assign w_inflight_next = r_inflight + c_CW'(w_accept) - c_CW'(w_rsp);
    // Masking keeps all redirect_pc bits in use while forcing word alignment.
    assign w_redirect_pc   = redirect_pc & ~XLEN'(3);

    // Every request still outstanding after a redirect is stale, including
    // one accepted in the redirect cycle itself.
    always_comb begin
        w_drop_next = r_drop_cnt;
        if (redirect_valid) begin
            w_drop_next = w_inflight_next;
        end else if (w_rsp && (r_drop_cnt != '0)) begin
            w_drop_next = r_drop_cnt - c_CW'(1);
        end
    end

    // DRAIN tracks drop_cnt>0, so entry is judged on the post-redirect count.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  w_state_next = ST_RUN;
            ST_RUN:   if (redirect_valid && (w_inflight_next != '0)) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_drop_next == '0) w_state_next = ST_RUN;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_inflight_next;
            r_drop_cnt <= w_drop_next;

            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end

            // Tags stay in lockstep with the memory, including dropped words.
            if (w_accept) r_tag_wr <= r_tag_wr + c_AW'(1);
            if (w_rsp)    r_tag_rd <= r_tag_rd + c_AW'(1);

            if (redirect_valid) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
                r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
            end
        end
    end

    // Storage arrays need no reset: occupancy is governed by the pointers.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag[r_tag_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_data[r_wr_ptr] <= imem_rsp_data;
            r_pc[r_wr_ptr]   <= r_tag[r_tag_rd];
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign inst_valid     = (r_count != '0);
    assign inst           = inst_valid ? r_data[r_rd_ptr] : c_NOP;
    assign inst_pc        = inst_valid ? r_pc[r_rd_ptr] : '0;
    assign opcode         = inst[6:0];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Directed self-checking bench for instr_fetch_queue. Acts as a
//               fixed-latency in-order instruction memory and as the decoder,
//               checking every accepted address and every delivered word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic        inst_ready;

    int          checks = 0;
    int          errors = 0;
    int          lat    = 1;
    logic        pipe_v [8];
    logic [31:0] pipe_a [8];
    logic [31:0] exp_req;
    logic [31:0] exp_next;
    logic [31:0] last_acc_addr;
    logic        acc_flag;
    int          acc_cnt;
    int          pop_cnt;

    instr_fetch_queue #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .opcode         (opcode),
        .inst_ready     (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // Memory contents: distinct word per address, opcode field varies.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, score them after it,
    // then advance the memory pipeline and drive the next response.
    task automatic tick();
        logic        acc;
        logic        pop;
        logic        rdr;
        logic [31:0] a;
        logic [31:0] ipc;
        logic [31:0] iw;
        logic [6:0]  op;
        logic [31:0] tgt;
        logic [31:0] w;
        #1;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        pop = inst_valid && inst_ready;
        ipc = inst_pc;
        iw  = inst;
        op  = opcode;
        rdr = redirect_valid;
        tgt = redirect_pc & 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
        acc_flag = acc;
        if (acc) begin
            check("req_addr", a, exp_req);
            exp_req       = exp_req + 32'd4;
            last_acc_addr = a;
            acc_cnt++;
        end
        if (rdr) begin
            exp_req  = tgt;
            exp_next = tgt;
        end else if (pop) begin
            w = word_of(exp_next);
            check("inst_pc", ipc, exp_next);
            check("inst", iw, w);
            check("opcode", {25'b0, op}, {25'b0, w[6:0]});
            exp_next = exp_next + 32'd4;
            pop_cnt++;
        end
        for (int i = 0; i < 7; i++) begin
            pipe_v[i] = pipe_v[i+1];
            pipe_a[i] = pipe_a[i+1];
        end
        pipe_v[7] = 1'b0;
        if (acc) begin
            pipe_v[lat-1] = 1'b1;
            pipe_a[lat-1] = a;
        end
        imem_rsp_valid = pipe_v[0];
        imem_rsp_data  = pipe_v[0] ? word_of(pipe_a[0]) : 32'h0;
    endtask

    // Asserts reset between edges, checks outputs at once, holds two
    // cycles and releases.
    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) pipe_v[i] = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        exp_req        = 32'h0;
        exp_next       = 32'h0;
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_opcode", {25'b0, opcode}, 32'h13);
        check("rst_inst_pc", inst_pc, 32'h0);
        tick();
        tick();
        reset   = 1'b0;
        acc_cnt = 0;
        pop_cnt = 0;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (inst_valid) break;
            tick();
        end
        check("wait_valid", {31'b0, inst_valid}, 32'd1);
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;
        acc_flag       = 1'b0;
        last_acc_addr  = 32'h0;
        acc_cnt        = 0;
        pop_cnt        = 0;
        for (int i = 0; i < 8; i++) begin
            pipe_v[i] = 1'b0;
            pipe_a[i] = 32'h0;
        end
        @(posedge clk);
        #1;

        // Streaming with a 1-cycle memory and an always-ready consumer.
        lat = 1;
        do_reset();
        check("t1_idle_no_req", {31'b0, imem_req_valid}, 32'd0);
        tick();
        check("t1_first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("t1_first_req_addr", imem_req_addr, 32'h0);
        tick();
        check("t1_not_yet_valid", {31'b0, inst_valid}, 32'd0);
        tick();
        check("t1_first_valid", {31'b0, inst_valid}, 32'd1);
        check("t1_first_pc", inst_pc, 32'h0);
        check("t1_first_inst", inst, word_of(32'h0));
        pop_cnt = 0;
        repeat (8) tick();
        check("t1_throughput", pop_cnt, 32'd8);

        // Consumer stalled: request credit stops at DEPTH words.
        inst_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        check("t2_req_count", acc_cnt, 32'd4);
        check("t2_req_blocked", {31'b0, imem_req_valid}, 32'd0);
        check("t2_head_valid", {31'b0, inst_valid}, 32'd1);
        check("t2_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        check("t2_blocked_until_pop", {31'b0, imem_req_valid}, 32'd0);
        tick();
        check("t2_req_after_pop", {31'b0, imem_req_valid}, 32'd1);
        check("t2_addr_after_pop", imem_req_addr, 32'h10);
        repeat (8) tick();

        // 3-cycle memory, redirect with exactly two requests outstanding.
        lat = 3;
        do_reset();
        tick();
        tick();
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        check("t3_flushed", {31'b0, inst_valid}, 32'd0);
        check("t3_new_addr", imem_req_addr, 32'h100);
        check("t3_req_valid", {31'b0, imem_req_valid}, 32'd1);
        wait_valid(20);
        check("t3_first_pc", inst_pc, 32'h100);
        check("t3_first_inst", inst, word_of(32'h100));

        // Redirect coinciding with a request accept and a response.
        for (int i = 0; i < 20; i++) begin
            if (imem_req_valid && imem_rsp_valid) break;
            tick();
        end
        check("t4_setup", {31'b0, imem_req_valid && imem_rsp_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        check("t4_flushed", {31'b0, inst_valid}, 32'd0);
        check("t4_new_addr", imem_req_addr, 32'h300);
        wait_valid(30);
        check("t4_first_pc", inst_pc, 32'h300);
        repeat (6) tick();

        // Unaligned redirect target and address wrap at the top of memory.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        check("t5_aligned_addr", imem_req_addr, 32'h200);
        wait_valid(30);
        check("t5_aligned_pc", inst_pc, 32'h200);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        check("t5_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 20; i++) begin
            if (acc_flag && (last_acc_addr == 32'hFFFF_FFFC)) break;
            tick();
        end
        check("t5_top_accepted", last_acc_addr, 32'hFFFF_FFFC);
        check("t5_wrap_addr", imem_req_addr, 32'h0);
        wait_valid(30);
        check("t5_top_pc", inst_pc, 32'hFFFF_FFFC);
        repeat (6) tick();

        // Reset with three words buffered, stray response during restart.
        lat        = 1;
        inst_ready = 1'b0;
        do_reset();
        repeat (5) tick();
        check("t6_buffered_valid", {31'b0, inst_valid}, 32'd1);
        check("t6_buffered_pc", inst_pc, 32'h0);
        do_reset();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        inst_ready = 1'b1;
        wait_valid(10);
        check("t6_restart_pc", inst_pc, 32'h0);
        check("t6_restart_inst", inst, word_of(32'h0));
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
